// File: rtl/iir_ctrl_pkg.sv
// Shared definitions for the IIR sequencer: FSM state encoding and default sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package iir_ctrl_pkg;

    localparam int DEF_AW       = 20;
    localparam int DEF_CLR_CYC  = 5;
    localparam int DEF_CORE_LAT = 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/iir_seq_ctrl_if.sv
// Control/memory-side bundle of the IIR sequencer (job control, read/write addressing, core strobes).
// Latency: n/a (wires only).
// Backpressure: hold stalls the sequencer; no other flow control.
// Ports: start/abort/len/hold from controller; RAddr/core_clr/core_en/WEN/WAddr/busy/Finish
// to memories and core; stall_cnt only when IIR_PERF_CNT_EN is defined.
import iir_ctrl_pkg::*;

interface iir_seq_ctrl_if #(parameter int AW = DEF_AW);
    logic          start;
    logic          abort;
    logic [AW-1:0] len;
    logic          hold;
    logic [AW-1:0] RAddr;
    logic          core_clr;
    logic          core_en;
    logic          WEN;
    logic [AW-1:0] WAddr;
    logic          busy;
    logic          Finish;
`ifdef IIR_PERF_CNT_EN
    logic [AW-1:0] stall_cnt;

    modport slave  (input  start, abort, len, hold,
                    output RAddr, core_clr, core_en, WEN, WAddr, busy, Finish, stall_cnt);
    modport master (output start, abort, len, hold,
                    input  RAddr, core_clr, core_en, WEN, WAddr, busy, Finish, stall_cnt);
`else
    modport slave  (input  start, abort, len, hold,
                    output RAddr, core_clr, core_en, WEN, WAddr, busy, Finish);
    modport master (output start, abort, len, hold,
                    input  RAddr, core_clr, core_en, WEN, WAddr, busy, Finish);
`endif
endinterface

// File: rtl/iir_valid_pipe.sv
// Stallable valid shift register tracking core_en through the IIR core pipeline.
// Latency: DEPTH advancing cycles (DEPTH=0 is a plain wire).
// Backpressure: stall freezes every stage and masks the output; flush empties all stages.
// Ports: clk, rst (sync, active-high), flush, stall, in_vld -> out_vld.
module iir_valid_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic stall,
    input  logic in_vld,
    output logic out_vld
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, rst, flush, stall};
            assign out_vld     = in_vld;
        end else begin : g_sr
            logic [DEPTH-1:0] sr;

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    sr <= '0;
                end else if (!stall) begin
                    sr[0] <= in_vld;
                    for (int i = 1; i < DEPTH; i++) begin
                        sr[i] <= sr[i-1];
                    end
                end
            end

            // A stalled memory cannot accept a write, so the output is masked too.
            assign out_vld = sr[DEPTH-1] & ~stall;
        end
    endgenerate

endmodule

// File: rtl/iir_seq_ctrl.sv
// Sequencer for the streaming IIR datapath: flush core state, read len samples, strobe core, write results.
// Latency: first WEN CLR_CYC+2+CORE_LAT cycles after start; Finish at CLR_CYC+len+CORE_LAT+2 with no stalls.
// Backpressure: hold freezes RAddr, core_en, the valid pipe and WAddr. Optional IIR_PERF_CNT_EN adds stall_cnt.
// Ports: clk, rst (sync, active-high), bus (iir_seq_ctrl_if.slave).
import iir_ctrl_pkg::*;

module iir_seq_ctrl #(
    parameter int AW       = DEF_AW,
    parameter int CORE_LAT = DEF_CORE_LAT,
    parameter int CLR_CYC  = DEF_CLR_CYC
) (
    input  logic          clk,
    input  logic          rst,
    iir_seq_ctrl_if.slave bus
);

    localparam int CW = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

    state_t        state_q, state_d;
    logic [AW-1:0] len_q;
    logic [AW-1:0] raddr_q;
    logic [AW-1:0] waddr_q;
    logic [CW-1:0] clr_cnt_q;
    logic          core_en_q;

    logic start_ok, rd_issue, core_clr, busy, finish, core_en, wen;

    // Starts are only honoured between jobs, and abort always wins.
    assign start_ok = bus.start && !bus.abort && (state_q == IDLE || state_q == DONE);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        core_clr = 1'b0;
        busy     = 1'b0;
        finish   = 1'b0;
        rd_issue = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) state_d = (bus.len == '0) ? DONE : CLEAR;
            end
            CLEAR: begin
                core_clr = 1'b1;
                busy     = 1'b1;
                if (clr_cnt_q == CW'(CLR_CYC - 1)) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (!bus.hold) begin
                    rd_issue = 1'b1;
                    if (raddr_q == len_q - AW'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                // Leave on the last write itself so Finish is not a cycle late.
                if (wen && waddr_q == len_q - AW'(1)) state_d = DONE;
            end
            DONE: begin
                finish = 1'b1;
                if (start_ok) state_d = (bus.len == '0) ? DONE : CLEAR;
            end
            default: state_d = IDLE;
        endcase
        if (bus.abort) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst || bus.abort) begin
            len_q     <= '0;
            raddr_q   <= '0;
            waddr_q   <= '0;
            clr_cnt_q <= '0;
            core_en_q <= 1'b0;
        end else begin
            if (start_ok) begin
                len_q     <= bus.len;
                raddr_q   <= '0;
                waddr_q   <= '0;
                clr_cnt_q <= '0;
            end
            if (state_q == CLEAR) clr_cnt_q <= clr_cnt_q + CW'(1);
            if (rd_issue)         raddr_q   <= raddr_q + AW'(1);
            if (wen)              waddr_q   <= waddr_q + AW'(1);
            // The issue flag waits out a stall so DIn is consumed once it is released.
            if (!bus.hold)        core_en_q <= rd_issue;
        end
    end

    assign core_en = core_en_q & ~bus.hold;

    iir_valid_pipe #(.DEPTH(CORE_LAT)) u_valid_pipe (
        .clk     (clk),
        .rst     (rst),
        .flush   (bus.abort),
        .stall   (bus.hold),
        .in_vld  (core_en),
        .out_vld (wen)
    );

`ifdef IIR_PERF_CNT_EN
    logic [AW-1:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst || bus.abort || start_ok) stall_q <= '0;
        else if (bus.hold && busy && stall_q != '1) stall_q <= stall_q + AW'(1);
    end

    assign bus.stall_cnt = stall_q;
`endif

    assign bus.RAddr    = raddr_q;
    assign bus.WAddr    = waddr_q;
    assign bus.core_clr = core_clr;
    assign bus.core_en  = core_en;
    assign bus.WEN      = wen;
    assign bus.busy     = busy;
    assign bus.Finish   = finish;

endmodule
